// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load and gap-free frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int CW = $clog2(FL + 1);
    localparam logic [CW-1:0] LAST = CW'(FL - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q;
    logic [FL-1:0] sreg_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    logic [FL-1:0] frame_d;
    logic [FL-1:0] shift_d;
    logic          accept;

    always_comb begin
`ifdef PISO_PARITY_EN
        frame_d = MSB_FIRST ? {load_data, ^load_data}
                            : {^load_data, load_data};
`else
        frame_d = load_data;
`endif
        // Zeros shift in behind the head so an emptied register reads 0.
        if (MSB_FIRST) begin
            shift_d = {sreg_q[FL-2:0], 1'b0};
        end else begin
            shift_d = {1'b0, sreg_q[FL-1:1]};
        end
    end

    assign load_ready = (state_q == IDLE) || done_q;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        sreg_q  <= frame_d;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt_q == LAST) begin
                        cnt_q  <= '0;
                        done_q <= 1'b0;
                        if (accept) begin
                            sreg_q <= frame_d;
                        end else begin
                            state_q <= IDLE;
                            sreg_q  <= '0;
                        end
                    end else begin
                        sreg_q <= shift_d;
                        cnt_q  <= cnt_q + CW'(1);
                        done_q <= (cnt_q + CW'(1)) == LAST;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ser_out   = MSB_FIRST ? sreg_q[FL-1] : sreg_q[0];
    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out shifter that feeds the data (d) input of the team's d_ff output stage. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on ser_out. It flags each bit with ser_valid and pulses done on the last bit. It supports gap-free back-to-back words.

Parameters:
WIDTH, 8, word width in bits; legal range 2 to 64.
MSB_FIRST, 1, 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-low (0 = reset).
load_valid  input  1  upstream presents load_data.
load_ready  output  1  block can accept a word this cycle.
load_data  input  WIDTH  parallel word.
ser_out  output  1  serial bit; connects to downstream d.
ser_valid  output  1  ser_out carries a valid bit this cycle.
busy  output  1  high while in SHIFT.
done  output  1  high during the cycle ser_out carries the final bit of a frame.

Behaviour:
- Reset (rst=0): takes effect asynchronously and is held while low.
  - state=IDLE, shift register=0, bit counter=0.
  - Outputs: ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1.
- Accept: a word is accepted on a rising edge where load_valid=1 and load_ready=1.
- States:
  - IDLE: load_ready=1, ser_out=0, ser_valid=0, busy=0. An accept captures load_data, sets counter=0 and moves to SHIFT.
  - SHIFT: ser_valid=1, busy=1. ser_out is a registered output driven directly from the shift-register head bit (MSB when MSB_FIRST=1, LSB otherwise). Each edge shifts by one and increments the counter.
- Latency: the first bit appears on ser_out in the cycle following the accept edge. One frame occupies exactly FRAME_LEN consecutive ser_valid cycles.
  - FRAME_LEN = WIDTH, or WIDTH+1 when parity is enabled (see Optional Feature).
- Last bit (counter = FRAME_LEN-1):
  - done=1 and load_ready=1.
  - If an accept occurs on that edge: the new word loads, the counter resets to 0, and SHIFT continues with no idle gap (ser_valid stays 1).
  - Otherwise: return to IDLE; ser_out=0 and ser_valid=0 on the next cycle.
- Outside the last bit in SHIFT: load_ready=0. load_valid and load_data are ignored, and no word is captured or dropped silently on the requester side, because ready was low.
- Counter width: $clog2(FRAME_LEN+1) bits. The counter never exceeds FRAME_LEN-1 and never wraps.
- Reset asserted mid-frame: the frame is abandoned immediately with no partial done. After rst returns to 1, the block is in IDLE with load_ready=1.
- Changes on load_data after the accept edge have no effect on the frame in progress.

Optional Feature:
Macro name: PISO_PARITY_EN.
- Defined: one even-parity bit (XOR of all WIDTH data bits, computed at accept) is appended after the last data bit. FRAME_LEN = WIDTH+1, and done asserts on the parity-bit cycle.
- Not defined: no parity logic is present, FRAME_LEN = WIDTH, and done asserts on the final data bit.

Test Plan:
1. Reset and idle. Hold rst=0 for 3 cycles, then release with load_valid=0 for 5 cycles. Required: ser_out=0, ser_valid=0, busy=0, done=0 and load_ready=1 throughout.
2. MSB-first frame. MSB_FIRST=1, WIDTH=8, accept 0xC1. Required on ser_out over 8 consecutive ser_valid cycles: 1,1,0,0,0,0,0,1. done=1 only on the 8th cycle, then IDLE the following cycle.
3. LSB-first frame. MSB_FIRST=0, WIDTH=8, accept 0xC1. Required on ser_out: 1,0,0,0,0,0,1,1.
4. Back-to-back frames. Accept 0xC1, then hold load_valid=1 with 0x3E until accepted on the last-bit edge. Required: 16 unbroken ser_valid cycles with bits 1,1,0,0,0,0,0,1,0,0,1,1,1,1,1,0 (MSB_FIRST=1), and done on cycles 8 and 16.
5. Busy rejection and reset mid-frame.
   - Drive load_valid=1 with 0xFF during bit 2 of a 0xC1 frame. Required: no capture; the 0xC1 bits are unchanged.
   - Drop rst to 0 during bit 4. Required: ser_out, ser_valid and busy go to 0 immediately with no done, and load_ready=1 after release.
6. Parity build. With PISO_PARITY_EN defined, accept 0xC1 (3 ones). Required: 9 ser_valid cycles, the 9th bit = 1, and done on cycle 9.
